// File: rtl/sample_timer_ctrl.sv
// Programmable sample timer for the J1 I/O bus: prescaler plus period counter issuing a
// tick_req/tick_ack handshake to the measurement datapath, with overrun tracking and irq.
module sample_timer_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] d_in,
  input  logic        cs,
  input  logic [3:0]  addr,
  input  logic        rd,
  input  logic        wr,
  output logic [15:0] d_out,
  output logic        tick_req,
  input  logic        tick_ack,
  output logic        irq
);

  localparam logic [3:0] AddrCtrl   = 4'h0;
  localparam logic [3:0] AddrPresc  = 4'h2;
  localparam logic [3:0] AddrPeriod = 4'h4;
  localparam logic [3:0] AddrStatus = 4'h6;
  localparam logic [3:0] AddrCount  = 4'h8;
  localparam logic [3:0] AddrMissed = 4'hA;

  typedef enum logic [0:0] {
    StIdle,
    StRun
  } state_e;

  state_e      state_q, state_d;

  logic        en_q, en_d;
  logic        oneshot_q, oneshot_d;
  logic        irq_en_q, irq_en_d;
  logic [15:0] presc_q, presc_d;
  logic [15:0] period_q, period_d;
  logic [15:0] pcnt_q, pcnt_d;
  logic [15:0] count_q, count_d;
  logic [15:0] missed_q, missed_d;
  logic        done_q, done_d;
  logic        ovr_q, ovr_d;
  logic        tick_req_q, tick_req_d;
  logic        irq_q, irq_d;
  logic [15:0] d_out_q, d_out_d;

  logic        we;
  logic        re;
  logic        ctrl_wr;
  logic        status_wr;
  logic        start;
  logic        stop;
  logic        counting;
  logic        presc_tick;
  logic        expiry;
  logic        ovr_set;
  logic [15:0] rdata;

  // Bus decode and run-control events
  always_comb begin
    we         = cs && wr;
    re         = cs && rd;
    ctrl_wr    = we && (addr == AddrCtrl);
    status_wr  = we && (addr == AddrStatus);
    start      = ctrl_wr && d_in[0] && (state_q == StIdle);
    stop       = ctrl_wr && !d_in[0];
    counting   = (state_q == StRun) && !stop;
    // >= rather than == so a limit shrunk below the live count wraps at the next tick
    presc_tick = counting && (pcnt_q >= presc_q);
    expiry     = presc_tick && (count_q >= period_q);
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start) state_d = StRun;
      end
      StRun: begin
        if (stop) begin
          state_d = StIdle;
        end else if (expiry && oneshot_q) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Control and configuration registers
  always_comb begin
    en_d      = en_q;
    oneshot_d = oneshot_q;
    irq_en_d  = irq_en_q;
    presc_d   = presc_q;
    period_d  = period_q;
    if (ctrl_wr) begin
      en_d      = d_in[0];
      oneshot_d = d_in[1];
      irq_en_d  = d_in[2];
    end
    if (expiry && oneshot_q) en_d = 1'b0;
    if (we && (addr == AddrPresc))  presc_d  = d_in;
    if (we && (addr == AddrPeriod)) period_d = d_in;
  end

  // Prescaler and period counter
  always_comb begin
    pcnt_d  = pcnt_q;
    count_d = count_q;
    if (start) begin
      pcnt_d  = 16'h0000;
      count_d = 16'h0000;
    end else if (counting) begin
      pcnt_d = presc_tick ? 16'h0000 : pcnt_q + 16'd1;
      if (presc_tick) begin
        count_d = expiry ? 16'h0000 : count_q + 16'd1;
      end
    end
  end

  // Request handshake; an ack coinciding with expiry consumes the old request only
  always_comb begin
    tick_req_d = tick_req_q;
    ovr_set    = 1'b0;
    if (stop) begin
      tick_req_d = 1'b0;
    end else if (expiry) begin
      tick_req_d = 1'b1;
      ovr_set    = tick_req_q && !tick_ack;
    end else if (tick_req_q && tick_ack) begin
      tick_req_d = 1'b0;
    end
  end

  // Status flags: hardware set beats a simultaneous write-1-to-clear
  always_comb begin
    done_d   = (done_q & ~(status_wr & d_in[0])) | expiry;
    ovr_d    = (ovr_q  & ~(status_wr & d_in[1])) | ovr_set;
    missed_d = missed_q;
    if (we && (addr == AddrMissed)) begin
      missed_d = 16'h0000;
    end else if (ovr_set && (missed_q != 16'hFFFF)) begin
      missed_d = missed_q + 16'd1;
    end
    irq_d = irq_en_q & (done_q | ovr_q);
  end

  // Read mux
  always_comb begin
    rdata = 16'h0000;
    unique case (addr)
      AddrCtrl:   rdata = {13'h0000, irq_en_q, oneshot_q, en_q};
      AddrPresc:  rdata = presc_q;
      AddrPeriod: rdata = period_q;
      AddrStatus: rdata = {13'h0000, state_q == StRun, ovr_q, done_q};
      AddrCount:  rdata = count_q;
      AddrMissed: rdata = missed_q;
      default:    rdata = 16'h0000;
    endcase
    d_out_d = re ? rdata : 16'h0000;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= StIdle;
      en_q       <= 1'b0;
      oneshot_q  <= 1'b0;
      irq_en_q   <= 1'b0;
      presc_q    <= 16'h0000;
      period_q   <= 16'h0000;
      pcnt_q     <= 16'h0000;
      count_q    <= 16'h0000;
      missed_q   <= 16'h0000;
      done_q     <= 1'b0;
      ovr_q      <= 1'b0;
      tick_req_q <= 1'b0;
      irq_q      <= 1'b0;
      d_out_q    <= 16'h0000;
    end else begin
      state_q    <= state_d;
      en_q       <= en_d;
      oneshot_q  <= oneshot_d;
      irq_en_q   <= irq_en_d;
      presc_q    <= presc_d;
      period_q   <= period_d;
      pcnt_q     <= pcnt_d;
      count_q    <= count_d;
      missed_q   <= missed_d;
      done_q     <= done_d;
      ovr_q      <= ovr_d;
      tick_req_q <= tick_req_d;
      irq_q      <= irq_d;
      d_out_q    <= d_out_d;
    end
  end

  assign d_out    = d_out_q;
  assign tick_req = tick_req_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_sample_timer_ctrl.sv
// Directed bench for sample_timer_ctrl: timing, overrun, oneshot, coincident ack,
// live reprogramming, W1C and reset behaviour against hand-computed values.
module tb_sample_timer_ctrl;

  logic        clk;
  logic        rst;
  logic [15:0] d_in;
  logic        cs;
  logic [3:0]  addr;
  logic        rd;
  logic        wr;
  logic [15:0] d_out;
  logic        tick_req;
  logic        tick_ack;
  logic        irq;

  int n_checks = 0;
  int n_errors = 0;

  sample_timer_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .d_in     (d_in),
    .cs       (cs),
    .addr     (addr),
    .rd       (rd),
    .wr       (wr),
    .d_out    (d_out),
    .tick_req (tick_req),
    .tick_ack (tick_ack),
    .irq      (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [15:0] data);
    cs = 1'b1; wr = 1'b1; addr = a; d_in = data;
    tick();
    cs = 1'b0; wr = 1'b0; d_in = 16'h0000;
  endtask

  task automatic read_check(input string tag, input logic [3:0] a, input logic [15:0] exp);
    cs = 1'b1; rd = 1'b1; addr = a;
    tick();
    cs = 1'b0; rd = 1'b0;
    check_eq(tag, d_out, exp);
  endtask

  task automatic do_reset();
    rst = 1'b0; cs = 1'b0; rd = 1'b0; wr = 1'b0; tick_ack = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0; d_in = 16'h0000; cs = 1'b0; addr = 4'h0; rd = 1'b0; wr = 1'b0;
    tick_ack = 1'b0;
    repeat (2) tick();
    check_eq("rst_tick_req", {15'h0, tick_req}, 16'h0000);
    check_eq("rst_irq", {15'h0, irq}, 16'h0000);
    check_eq("rst_dout", d_out, 16'h0000);
    rst = 1'b1;
    read_check("rst_ctrl", 4'h0, 16'h0000);
    read_check("rst_status", 4'h6, 16'h0000);
    read_check("rst_count", 4'h8, 16'h0000);

    // Register map basics
    bus_write(4'h2, 16'h1234);
    read_check("presc_rw", 4'h2, 16'h1234);
    tick();
    check_eq("dout_idle_zero", d_out, 16'h0000);
    read_check("odd_addr", 4'h3, 16'h0000);
    bus_write(4'hC, 16'hFFFF);
    read_check("unmapped", 4'hC, 16'h0000);
    bus_write(4'h0, 16'hFFFE);
    read_check("ctrl_bits", 4'h0, 16'h0006);
    read_check("ctrl_no_run", 4'h6, 16'h0000);
    do_reset();

    // Periodic: PRESC=3, PERIOD=4, ack tied high -> pulse every 20 cycles
    tick_ack = 1'b1;
    bus_write(4'h2, 16'd3);
    bus_write(4'h4, 16'd4);
    bus_write(4'h0, 16'h0001);
    for (int i = 1; i <= 40; i++) begin
      tick();
      check_eq($sformatf("per_req_c%0d", i), {15'h0, tick_req},
               (i == 20 || i == 40) ? 16'h0001 : 16'h0000);
    end
    for (int k = 0; k <= 4; k++) begin
      read_check($sformatf("per_count_%0d", k), 4'h8, 16'(k));
      repeat (3) tick();
    end
    read_check("per_status", 4'h6, 16'h0005);
    check_eq("per_irq_off", {15'h0, irq}, 16'h0000);
    bus_write(4'h0, 16'h0000);
    do_reset();

    // Overrun: PRESC=0, PERIOD=2, ack low, IRQ_EN=1
    bus_write(4'h2, 16'd0);
    bus_write(4'h4, 16'd2);
    bus_write(4'h0, 16'h0005);
    for (int i = 1; i <= 9; i++) begin
      tick();
      check_eq($sformatf("ovr_req_c%0d", i), {15'h0, tick_req},
               (i >= 3) ? 16'h0001 : 16'h0000);
    end
    bus_write(4'h0, 16'h0004);
    check_eq("ovr_stop_req", {15'h0, tick_req}, 16'h0000);
    read_check("ovr_missed", 4'hA, 16'd2);
    read_check("ovr_status", 4'h6, 16'h0003);
    check_eq("ovr_irq", {15'h0, irq}, 16'h0001);
    bus_write(4'hA, 16'h0000);
    read_check("missed_clr", 4'hA, 16'h0000);
    // W1C: irq follows one cycle after the flags
    bus_write(4'h6, 16'h0003);
    read_check("w1c_status", 4'h6, 16'h0000);
    check_eq("w1c_irq", {15'h0, irq}, 16'h0000);
    do_reset();

    // Oneshot: PRESC=1, PERIOD=1 -> single request 4 cycles after start
    tick_ack = 1'b1;
    bus_write(4'h2, 16'd1);
    bus_write(4'h4, 16'd1);
    bus_write(4'h0, 16'h0003);
    for (int i = 1; i <= 10; i++) begin
      tick();
      check_eq($sformatf("os_req_c%0d", i), {15'h0, tick_req},
               (i == 4) ? 16'h0001 : 16'h0000);
    end
    read_check("os_status", 4'h6, 16'h0001);
    read_check("os_ctrl", 4'h0, 16'h0002);
    do_reset();

    // Coincident ack and expiry: request stays high, no overrun
    bus_write(4'h2, 16'd0);
    bus_write(4'h4, 16'd1);
    bus_write(4'h0, 16'h0001);
    for (int i = 1; i <= 4; i++) begin
      tick();
      if (i >= 2) check_eq($sformatf("co_req_c%0d", i), {15'h0, tick_req}, 16'h0001);
      if (i == 3) tick_ack = 1'b1;
      if (i == 4) tick_ack = 1'b0;
    end
    bus_write(4'h0, 16'h0000);
    read_check("co_status", 4'h6, 16'h0001);
    read_check("co_missed", 4'hA, 16'h0000);
    do_reset();

    // Live reprogramming: PERIOD 100 -> 5 with COUNT at 50
    bus_write(4'h2, 16'd0);
    bus_write(4'h4, 16'd100);
    bus_write(4'h0, 16'h0001);
    repeat (48) tick();
    read_check("live_count_pre", 4'h8, 16'd48);
    bus_write(4'h4, 16'd5);
    tick();
    check_eq("live_req", {15'h0, tick_req}, 16'h0001);
    read_check("live_count_wrap", 4'h8, 16'h0000);
    read_check("live_status", 4'h6, 16'h0005);
    check_eq("live_req_pending", {15'h0, tick_req}, 16'h0001);

    // Reset mid-RUN with a pending request
    rst = 1'b0;
    tick();
    check_eq("mid_rst_req", {15'h0, tick_req}, 16'h0000);
    check_eq("mid_rst_irq", {15'h0, irq}, 16'h0000);
    rst = 1'b1;
    read_check("mid_rst_ctrl", 4'h0, 16'h0000);
    read_check("mid_rst_presc", 4'h2, 16'h0000);
    read_check("mid_rst_period", 4'h4, 16'h0000);
    read_check("mid_rst_status", 4'h6, 16'h0000);
    read_check("mid_rst_count", 4'h8, 16'h0000);
    read_check("mid_rst_missed", 4'hA, 16'h0000);
    repeat (5) tick();
    check_eq("mid_rst_no_req", {15'h0, tick_req}, 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sample_timer_ctrl.md
SAMPLE_TIMER_CTRL -- requirements
Module: sample_timer_ctrl

Interface
REQ-001 SHALL have port clk, input, 1 bit: single system clock; all state changes on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous and active-low.
REQ-003 SHALL have port d_in, input, 16 bits: write data from the J1 I/O bus.
REQ-004 SHALL have port cs, input, 1 bit: peripheral select.
REQ-005 SHALL have port addr, input, 4 bits: register address, the 4 LSBs of the I/O address.
REQ-006 SHALL have port rd, input, 1 bit: read strobe.
REQ-007 SHALL have port wr, input, 1 bit: write strobe.
REQ-008 SHALL have port d_out, output, 16 bits: registered read data.
REQ-009 SHALL have port tick_req, output, 1 bit: sample request to the measurement datapath.
REQ-010 SHALL have port tick_ack, input, 1 bit: sample accepted by the datapath.
REQ-011 SHALL have port irq, output, 1 bit: interrupt, level.

Function
REQ-012 SHALL map registers as follows: 0x0 CTRL rw (bit0 EN, bit1 ONESHOT, bit2 IRQ_EN; other bits read 0); 0x2 PRESC rw, 16 bits; 0x4 PERIOD rw, 16 bits; 0x6 STATUS (bit0 DONE, bit1 OVR, bit2 RUN; DONE/OVR write-1-to-clear); 0x8 COUNT ro; 0xA MISSED ro; all other addresses read 0x0000 and ignore writes.
REQ-013 SHALL perform a register write at the rising edge where cs && wr.
REQ-014 SHALL update d_out at the rising edge where cs && rd with the addressed register, and SHALL load 0x0000 otherwise, giving 1-cycle read latency.
REQ-015 SHALL implement FSM states IDLE and RUN; STATUS.RUN = (state == RUN).
REQ-016 SHALL, on a CTRL write with EN=1 while in IDLE, clear the prescale counter and COUNT and enter RUN.
REQ-017 SHALL, on a CTRL write with EN=1 while in RUN, not restart the counters.
REQ-018 SHALL, on a CTRL write with EN=0, enter IDLE, hold COUNT, and deassert tick_req on the next edge.
REQ-019 SHALL, in RUN, increment the prescale counter each cycle and generate a prescale tick then reset the counter to 0 when counter >= PRESC.
REQ-020 SHALL, on each prescale tick, set COUNT to 0 and flag expiry if COUNT >= PERIOD, else increment COUNT.
REQ-021 SHALL produce an expiry interval of (PRESC+1)*(PERIOD+1) cycles; PRESC=0, PERIOD=0 gives expiry every cycle.
REQ-022 SHALL apply writes to PRESC/PERIOD in RUN immediately; the >= compares mean a shrunk limit wraps at the next tick, with no run past 0xFFFF.
REQ-023 SHALL, on expiry, set tick_req on the next edge and set DONE.
REQ-024 SHALL hold tick_req high until a cycle with tick_ack=1, then clear it on that edge; tick_ack while tick_req=0 is ignored.
REQ-025 SHALL, on expiry while tick_req=1 and tick_ack=0, set OVR, keep tick_req high, and increment MISSED, saturating at 0xFFFF.
REQ-026 SHALL treat expiry in the same cycle as tick_ack with tick_req=1 as the old request consumed and the new one issued: tick_req stays 1 and no OVR is raised.
REQ-027 SHALL, with ONESHOT=1, clear EN and enter IDLE at the first expiry; tick_req then follows REQ-024 normally.
REQ-028 SHALL let hardware set win over a simultaneous software W1C of DONE/OVR.
REQ-029 SHALL clear MISSED on any write to 0xA.
REQ-030 SHALL drive irq = IRQ_EN & (DONE | OVR), registered.

Reset
REQ-031 SHALL, while rst=0 at a rising edge, clear CTRL, PRESC, PERIOD, COUNT, MISSED, DONE, OVR, the prescale counter, d_out, tick_req and irq to 0 and set state to IDLE.
REQ-032 SHALL, on reset asserted mid-RUN with tick_req=1, drop tick_req on that edge and discard the pending request.

Verification
REQ-033 SHALL verify periodic timing: PRESC=3, PERIOD=4, EN=1, tick_ack tied high -> tick_req pulses 1 cycle every 20 cycles, DONE set, COUNT read cycles 0..4.
REQ-034 SHALL verify overrun: PRESC=0, PERIOD=2, tick_ack held 0 for 10 cycles -> tick_req stays 1, OVR=1, MISSED=2, irq=1 with IRQ_EN=1.
REQ-035 SHALL verify oneshot: ONESHOT=1, EN=1, PRESC=1, PERIOD=1 -> a single tick_req 4 cycles after start, then STATUS.RUN=0 and CTRL.EN reads 0.
REQ-036 SHALL verify coincident ack and expiry: tick_ack asserted in the expiry cycle -> tick_req continuous, OVR=0, MISSED unchanged.
REQ-037 SHALL verify live reprogramming: PERIOD written from 100 to 5 while COUNT=50 -> COUNT returns to 0 at the next prescale tick, with expiry flagged.
REQ-038 SHALL verify W1C and reset: writing 0x0003 to STATUS clears DONE/OVR and irq falls the next cycle; rst=0 mid-RUN -> all registers read 0x0000.
